// File: rtl/gf_exp_pkg.sv
// Shared types and constants for the GF(2^8) exponentiation engine.
package gf_exp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQR  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } gf_exp_state_e;

    localparam logic [7:0] GF_ONE     = 8'h01;
    localparam logic [7:0] GF_INV_EXP = 8'hFE;
    // AES field polynomial x^8+x^4+x^3+x+1; the low byte is the reduction term.
    localparam logic [8:0] GF_POLY    = 9'h11B;

endpackage

// File: rtl/gf_exp_seq_gfmul_8.sv
// Combinational GF(2^8) multiplier over the AES polynomial (shift-and-add).
module gfmul_8
    import gf_exp_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_p
);

    logic [7:0] w_p;
    logic [7:0] w_a;

    // Accumulate a*x^i for each set bit of b, reducing a by the polynomial after each shift.
    always_comb begin
        w_p = 8'h00;
        w_a = i_a;
        for (int i = 0; i < 8; i++) begin
            if (i_b[i]) w_p = w_p ^ w_a;
            w_a = {w_a[6:0], 1'b0} ^ (w_a[7] ? GF_POLY[7:0] : 8'h00);
        end
    end

    assign o_p = w_p;

endmodule

// File: rtl/gf_exp_seq.sv
// Sequential GF(2^8) exponentiation, left-to-right square-and-multiply on one
// shared multiplier. Constant-time: every exponent bit costs one SQR and one MUL.
// Optional feature macro: GF_EXP_INV_EN adds inv_i, which forces exponent 0xFE
// (multiplicative inverse) at the input handshake.
module gf_exp_seq
    import gf_exp_pkg::*;
#(
    parameter int EXP_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [7:0]       base_i,
    input  logic [EXP_W-1:0] exp_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [7:0]       result_o,
    output logic             busy_o
`ifdef GF_EXP_INV_EN
    ,
    input  logic             inv_i
`endif
);

    localparam int CNT_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    gf_exp_state_e    r_state;
    gf_exp_state_e    w_state_nxt;
    logic [7:0]       r_acc;
    logic [7:0]       r_base;
    logic [EXP_W-1:0] r_exp;
    logic [CNT_W-1:0] r_cnt;

    logic             w_in_fire;
    logic [EXP_W-1:0] w_exp_cap;
    logic [7:0]       w_mul_b;
    logic [7:0]       w_mul_p;

`ifdef GF_EXP_INV_EN
    if (EXP_W < 8) begin : g_exp_w_chk
        $error("gf_exp_seq: EXP_W must be >= 8 when GF_EXP_INV_EN is defined");
    end
    assign w_exp_cap = inv_i ? EXP_W'(GF_INV_EXP) : exp_i;
`else
    assign w_exp_cap = exp_i;
`endif

    assign w_in_fire = in_valid_i && (r_state == IDLE);

    // Squaring reuses acc on both ports; otherwise multiply by base or by one,
    // so the multiplier does the same work whatever the exponent bit is.
    assign w_mul_b = (r_state == SQR) ? r_acc : (r_exp[r_cnt] ? r_base : GF_ONE);

    gfmul_8 u_gfmul (
        .i_a (r_acc),
        .i_b (w_mul_b),
        .o_p (w_mul_p)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b0;
                if (in_valid_i) w_state_nxt = SQR;
            end
            SQR:  w_state_nxt = MUL;
            MUL:  w_state_nxt = (r_cnt == '0) ? DONE : SQR;
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture, accumulator update and bit counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_acc  <= 8'h00;
            r_base <= 8'h00;
            r_exp  <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_in_fire) begin
                r_base <= base_i;
                r_exp  <= w_exp_cap;
                r_acc  <= GF_ONE;
                r_cnt  <= CNT_W'(EXP_W - 1);
            end
            if (r_state == SQR) r_acc <= w_mul_p;
            if (r_state == MUL) begin
                r_acc <= w_mul_p;
                if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign result_o = r_acc;

endmodule
